// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Round-robin read-side scheduler that shares one downstream consumer
//   between NUM_PORTS FIFOs whose read ports all run on clk.
//   A grant lasts for a burst of up to MAX_BURST pops. The words come back
//   READ_LATENCY clocks after rd_en and are merged into a single stream
//   tagged with the index of the FIFO they came from.
//
// Ports
//   clk           read clock shared by every arbitrated FIFO
//   reset         asynchronous, active-high
//   enable        allows new grants; dropping it ends the current burst
//   fifo_rd_empty per-FIFO empty flags
//   fifo_rd_data  per-FIFO read data; port i at [i*WIDTH +: WIDTH]
//   fifo_rd_en    per-FIFO read enables, one-hot or zero
//   out_valid     out_data/out_src hold a popped word this cycle
//   out_data      popped word
//   out_src       index of the FIFO out_data came from
//   grant_active  high while a burst is in progress
//   grant_id      currently or most recently granted port
module fifo_drain_arbiter #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned IDW         = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_PORTS-1:0]       fifo_rd_empty,
  input  logic [NUM_PORTS*WIDTH-1:0] fifo_rd_data,
  output logic [NUM_PORTS-1:0]       fifo_rd_en,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [IDW-1:0]             out_src,
  output logic                       grant_active,
  output logic [IDW-1:0]             grant_id
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last, last_nxt, grant_nxt, sel;
  logic [CW-1:0]  count, count_nxt;
  logic           sel_found;
  logic           rd_issue;
  int unsigned    cand;

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [IDW-1:0]          src_pipe [READ_LATENCY];
  logic [WIDTH-1:0]        port_word [NUM_PORTS];

  // Round-robin search starting just after the last granted port. The
  // index wraps explicitly so non-power-of-2 port counts work.
  always_comb begin
    sel       = last;
    sel_found = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = 32'(last) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!sel_found && !fifo_rd_empty[IDW'(cand)]) begin
        sel       = IDW'(cand);
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      last     <= IDW'(NUM_PORTS - 1);
      count    <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last     <= last_nxt;
      count    <= count_nxt;
    end
  end

  // IDLE never pops, which leaves exactly one bubble between bursts.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last;
    count_nxt = count;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && sel_found) begin
          grant_nxt = sel;
          last_nxt  = sel;
          count_nxt = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        rd_issue = enable && !fifo_rd_empty[grant_id] && (count < CW'(MAX_BURST));
        if (rd_issue) begin
          count_nxt = count + 1'b1;
          if (count == CW'(MAX_BURST - 1)) state_nxt = IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = '0;
    if (rd_issue) fifo_rd_en[grant_id] = 1'b1;
  end

  assign grant_active = (state == BURST);

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_word[p] = fifo_rd_data[p*WIDTH +: WIDTH];
    end
  end

  // Delay line of {issued, port} that tracks the FIFO memory latency. It is
  // independent of the FSM, so words of an earlier burst still drain while
  // another port is already being granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) src_pipe[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      src_pipe[0] <= grant_id;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        src_pipe[i] <= src_pipe[i-1];
      end
      out_valid <= vld_pipe[READ_LATENCY-1];
      out_src   <= src_pipe[READ_LATENCY-1];
      if (vld_pipe[READ_LATENCY-1]) out_data <= port_word[src_pipe[READ_LATENCY-1]];
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: two instances (READ_LATENCY 2 and 1) each
// drain their own set of behavioural FIFOs; a cycle-level reference of the
// scheduling rules predicts rd_en, grants and the tagged output stream.
module tb_fifo_drain_arbiter;

  localparam int NP    = 4;
  localparam int W     = 16;
  localparam int MB    = 8;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;

  logic [NP-1:0]   empty_d [2];
  logic [NP*W-1:0] data_d  [2];
  logic [NP-1:0]   rd_en   [2];
  logic            ov      [2];
  logic [W-1:0]    od      [2];
  logic [1:0]      osrc    [2];
  logic            ga      [2];
  logic [1:0]      gid     [2];

  always #5 clk = ~clk;

  fifo_drain_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .MAX_BURST(MB), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_rd_empty(empty_d[0]), .fifo_rd_data(data_d[0]), .fifo_rd_en(rd_en[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_src(osrc[0]),
    .grant_active(ga[0]), .grant_id(gid[0]));

  fifo_drain_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .MAX_BURST(MB), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_rd_empty(empty_d[1]), .fifo_rd_data(data_d[1]), .fifo_rd_en(rd_en[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_src(osrc[1]),
    .grant_active(ga[1]), .grant_id(gid[1]));

  // behavioural FIFOs
  logic [W-1:0] mem [2][NP][DEPTH];
  int           wr_cnt [2][NP];
  int           rd_cnt [2][NP];
  logic [W-1:0] st1 [2][NP];
  logic [W-1:0] st2 [2][NP];
  bit           underflow [2];
  logic [NP-1:0] rd_en_s [2];

  // reference model
  bit           m_busy [2];
  int           m_port [2], m_left [2], m_last [2], m_gid [2];
  int           m_rd [2][NP];
  int           e_due [2][256];
  int           e_src [2][256];
  logic [W-1:0] e_word [2][256];
  int           e_head [2], e_tail [2];

  int  cyc, n_cmp, n_bad;
  int  delivered [2];
  int  pulses [2];
  bit  rst_req, en_req;

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  task automatic push_words(input int p, input int n);
    logic [W-1:0] w;
    for (int j = 0; j < n; j++) begin
      w = W'($urandom);
      for (int k = 0; k < 2; k++) begin
        mem[k][p][wr_cnt[k][p]] = w;
        wr_cnt[k][p]++;
      end
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 1'b0;
    m_last[k] = NP - 1;
    m_gid[k]  = 0;
    m_left[k] = 0;
    e_head[k] = e_tail[k];
    // the FIFO is the authority on what was consumed before reset
    for (int p = 0; p < NP; p++) m_rd[k][p] = rd_cnt[k][p];
  endtask

  task automatic evaluate(input int k);
    logic [NP-1:0] exp_en;
    bit issue, ev;
    int h, t;
    string u;
    u  = (k == 0) ? "L2" : "L1";
    h  = e_head[k] & 255;
    ev = (e_head[k] != e_tail[k]) && (e_due[k][h] == cyc);
    if (rd_en[k] != '0) pulses[k]++;
    if (reset) begin
      check($sformatf("%s.rst_rd_en", u), rd_en[k], 0);
      check($sformatf("%s.rst_out_valid", u), ov[k], 0);
      check($sformatf("%s.rst_out_data", u), od[k], 0);
      check($sformatf("%s.rst_out_src", u), osrc[k], 0);
      check($sformatf("%s.rst_grant_active", u), ga[k], 0);
      check($sformatf("%s.rst_grant_id", u), gid[k], 0);
      return;
    end
    issue  = m_busy[k] && enable && !empty_d[k][m_port[k]] && (m_left[k] > 0);
    exp_en = '0;
    if (issue) exp_en[m_port[k]] = 1'b1;
    check($sformatf("%s.rd_en", u), rd_en[k], exp_en);
    check($sformatf("%s.grant_active", u), ga[k], m_busy[k]);
    check($sformatf("%s.grant_id", u), gid[k], m_gid[k]);
    check($sformatf("%s.out_valid", u), ov[k], ev);
    if (ev) begin
      check($sformatf("%s.out_src", u), osrc[k], e_src[k][h]);
      check($sformatf("%s.out_data", u), od[k], e_word[k][h]);
      delivered[k]++;
      e_head[k]++;
    end
    check($sformatf("%s.underflow", u), underflow[k], 0);
    if (m_busy[k]) begin
      if (issue) begin
        t = e_tail[k] & 255;
        e_due[k][t]  = cyc + lat(k) + 1;
        e_src[k][t]  = m_port[k];
        e_word[k][t] = mem[k][m_port[k]][m_rd[k][m_port[k]]];
        e_tail[k]++;
        m_rd[k][m_port[k]]++;
        m_left[k]--;
        if (m_left[k] == 0) m_busy[k] = 1'b0;
      end else begin
        m_busy[k] = 1'b0;
      end
    end else if (enable) begin
      for (int i = 1; i <= NP; i++) begin
        int p;
        p = (m_last[k] + i) % NP;
        if (!m_busy[k] && !empty_d[k][p]) begin
          m_busy[k] = 1'b1;
          m_port[k] = p;
          m_last[k] = p;
          m_gid[k]  = p;
          m_left[k] = MB;
        end
      end
    end
  endtask

  // One clock: FIFOs react to the edge, inputs are driven, then everything
  // is sampled 2 time units after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NP; p++) begin
        st2[k][p] = st1[k][p];
        if (rd_en_s[k][p]) begin
          if (wr_cnt[k][p] == rd_cnt[k][p]) begin
            underflow[k] = 1'b1;
          end else begin
            st1[k][p] = mem[k][p][rd_cnt[k][p]];
            rd_cnt[k][p]++;
          end
        end
        empty_d[k][p] = (wr_cnt[k][p] == rd_cnt[k][p]);
        data_d[k][p*W +: W] = (lat(k) == 1) ? st1[k][p] : st2[k][p];
      end
    end
    enable = en_req;
    reset  = rst_req;
    #1;
    for (int k = 0; k < 2; k++) begin
      evaluate(k);
      rd_en_s[k] = rd_en[k];
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic mid_reset();
    #2;
    reset   = 1'b1;
    rst_req = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async_rst.rd_en%0d", k), rd_en[k], 0);
      check($sformatf("async_rst.out_valid%0d", k), ov[k], 0);
      check($sformatf("async_rst.out_data%0d", k), od[k], 0);
      check($sformatf("async_rst.out_src%0d", k), osrc[k], 0);
      check($sformatf("async_rst.grant_active%0d", k), ga[k], 0);
      check($sformatf("async_rst.grant_id%0d", k), gid[k], 0);
      model_reset(k);
      rd_en_s[k] = rd_en[k];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d [2];
    int p0 [2];
    int left;
    cyc = 0; n_cmp = 0; n_bad = 0;
    for (int k = 0; k < 2; k++) begin
      empty_d[k] = '1; data_d[k] = '0; rd_en_s[k] = '0;
      underflow[k] = 1'b0; delivered[k] = 0; pulses[k] = 0;
      e_head[k] = 0; e_tail[k] = 0;
      for (int p = 0; p < NP; p++) begin
        wr_cnt[k][p] = 0; rd_cnt[k][p] = 0; st1[k][p] = '0; st2[k][p] = '0;
      end
      model_reset(k);
    end
    en_req  = 1'b0;
    rst_req = 1'b1;
    #1 reset = 1'b1;
    run(2);
    rst_req = 1'b0;
    run(2);
    en_req = 1'b1;

    // single source: 20 words on port 2 -> bursts of 8, 8, 4
    for (int k = 0; k < 2; k++) d[k] = delivered[k];
    push_words(2, 20);
    run(40);
    for (int k = 0; k < 2; k++) check($sformatf("single.words%0d", k), delivered[k] - d[k], 20);

    // round robin over four full ports
    for (int k = 0; k < 2; k++) d[k] = delivered[k];
    for (int p = 0; p < NP; p++) push_words(p, 16);
    run(90);
    for (int k = 0; k < 2; k++) check($sformatf("rr.words%0d", k), delivered[k] - d[k], 64);

    // port runs empty mid-burst, next port takes over
    for (int k = 0; k < 2; k++) d[k] = delivered[k];
    push_words(1, 3);
    push_words(2, 8);
    run(40);
    for (int k = 0; k < 2; k++) check($sformatf("short.words%0d", k), delivered[k] - d[k], 11);

    // enable dropped after the 4th pop of a burst
    for (int k = 0; k < 2; k++) begin d[k] = delivered[k]; p0[k] = pulses[k]; end
    push_words(0, 16);
    for (int i = 0; i < 50 && (pulses[0] - p0[0]) < 4; i++) cycle();
    check("edrop.reach4", pulses[0] - p0[0], 4);
    en_req = 1'b0;
    run(10);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("edrop.pulses%0d", k), pulses[k] - p0[k], 4);
      check($sformatf("edrop.words%0d", k), delivered[k] - d[k], 4);
    end
    en_req = 1'b1;
    run(40);
    for (int k = 0; k < 2; k++) check($sformatf("edrop.total%0d", k), delivered[k] - d[k], 16);

    // asynchronous reset one cycle after a pop
    p0[0] = pulses[0];
    push_words(3, 10);
    for (int i = 0; i < 20 && pulses[0] == p0[0]; i++) cycle();
    check("arst.reach_pop", pulses[0] - p0[0], 1);
    cycle();
    mid_reset();
    for (int p = 0; p < 3; p++) push_words(p, 2);
    run(2);
    rst_req = 1'b0;
    cycle();
    for (int i = 0; i < 10 && !ga[0]; i++) cycle();
    check("arst.restart_active", ga[0], 1);
    check("arst.restart_port", gid[0], 0);
    check("arst.restart_port_l1", gid[1], 0);
    run(60);

    // randomized traffic with enable glitches and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int p;
        p = $urandom_range(0, NP - 1);
        if ((wr_cnt[0][p] - rd_cnt[0][p]) < 12 && wr_cnt[0][p] < DEPTH - 8)
          push_words(p, $urandom_range(1, 3));
      end
      en_req = ($urandom_range(0, 7) != 0);
      cycle();
      if (c == 1000 || c == 2000) begin
        mid_reset();
        cycle();
        rst_req = 1'b0;
      end
    end
    en_req = 1'b1;
    run(150);
    for (int k = 0; k < 2; k++) begin
      left = 0;
      for (int p = 0; p < NP; p++) left += wr_cnt[k][p] - rd_cnt[k][p];
      check($sformatf("drain.fifo_words%0d", k), left, 0);
      check($sformatf("drain.pending%0d", k), e_tail[k] - e_head[k], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
